voice_table: RTL

- Sits directly downstream of the SPI MIDI decoder and consumes its note-on/note-off message bus.
- Holds per-voice state: gate, tuning code, velocity and a retrigger-pending bit.
- Continuously scans all voices round-robin and presents one voice per transfer on a valid/ready stream to the time-multiplexed NCO/envelope pipeline.
- Also tracks the number of gated voices and flags out-of-range messages.

---
 rtl/voice_table_if.sv | 37 +++
 rtl/voice_table.sv | 114 +++++++++++
 2 files changed

// File: rtl/voice_table_if.sv
// Message bus from the SPI MIDI decoder plus the voice scan stream toward the
// NCO/envelope pipeline; slave is the voice table, master is its environment.
interface voice_table_if #(
    parameter int VOICE_W  = 4,
    parameter int TUNING_W = 32,
    parameter int VEL_W    = 7
);
    logic                i_SPI_note_status;
    logic [7:0]          i_SPI_voice_index;
    logic [TUNING_W-1:0] i_SPI_tuning_code;
    logic [VEL_W-1:0]    i_SPI_velocity;
    logic                i_SPI_flag;
    logic                o_voice_valid;
    logic                i_voice_ready;
    logic [VOICE_W-1:0]  o_voice_index;
    logic                o_frame_start;
    logic                o_gate;
    logic                o_retrigger;
    logic [TUNING_W-1:0] o_tuning_code;
    logic [VEL_W-1:0]    o_velocity;
    logic [VOICE_W:0]    o_active_count;
    logic                o_drop;

    modport slave (
        input  i_SPI_note_status, i_SPI_voice_index, i_SPI_tuning_code,
               i_SPI_velocity, i_SPI_flag, i_voice_ready,
        output o_voice_valid, o_voice_index, o_frame_start, o_gate,
               o_retrigger, o_tuning_code, o_velocity, o_active_count, o_drop
    );

    modport master (
        output i_SPI_note_status, i_SPI_voice_index, i_SPI_tuning_code,
               i_SPI_velocity, i_SPI_flag, i_voice_ready,
        input  o_voice_valid, o_voice_index, o_frame_start, o_gate,
               o_retrigger, o_tuning_code, o_velocity, o_active_count, o_drop
    );
endinterface

// File: rtl/voice_table.sv
// Per-voice note state fed by the MIDI decoder, scanned round-robin onto a
// valid/ready stream, one voice per transfer.
module voice_table #(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = 4,
    parameter int TUNING_W   = 32,
    parameter int VEL_W      = 7
) (
    input logic          i_clk,
    input logic          i_reset,
    voice_table_if.slave bus
);
    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    typedef struct packed {
        logic                gate;
        logic                retrig;
        logic [TUNING_W-1:0] tuning;
        logic [VEL_W-1:0]    vel;
    } voice_word_t;

    state_t              r_state, w_state_nxt;
    logic                w_load;
    logic                r_flag_d;
    logic [NUM_VOICES-1:0] r_gate, r_retrig;
    logic [TUNING_W-1:0] r_tuning [NUM_VOICES];
    logic [VEL_W-1:0]    r_vel    [NUM_VOICES];
    logic [VOICE_W-1:0]  r_ptr, r_idx;
    logic                r_valid, r_frame, r_drop;
    logic [VOICE_W:0]    r_count;
    voice_word_t         r_word;

    // One event per flag high period, no matter how long the decoder holds it
    logic               w_event, w_in_range, w_on, w_off, w_cur_gate;
    logic [VOICE_W-1:0] w_vidx;
    assign w_event    = bus.i_SPI_flag & ~r_flag_d;
    assign w_in_range = 32'(bus.i_SPI_voice_index) < NUM_VOICES;
    assign w_vidx     = VOICE_W'(bus.i_SPI_voice_index);
    assign w_on       = w_event & w_in_range & bus.i_SPI_note_status;
    assign w_off      = w_event & w_in_range & ~bus.i_SPI_note_status;
    assign w_cur_gate = r_gate[w_vidx];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE:    w_state_nxt = S_PRESENT;
            S_PRESENT: w_load      = ~r_valid | bus.i_voice_ready;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Retrigger clear on load comes first so a same-cycle note-on set wins
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_flag_d <= 1'b0;
            r_gate   <= '0;
            r_retrig <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_tuning[i] <= '0;
                r_vel[i]    <= '0;
            end
        end else begin
            r_flag_d <= bus.i_SPI_flag;
            if (w_load) r_retrig[r_ptr] <= 1'b0;
            if (w_on) begin
                r_gate[w_vidx]   <= 1'b1;
                r_retrig[w_vidx] <= 1'b1;
                r_tuning[w_vidx] <= bus.i_SPI_tuning_code;
                r_vel[w_vidx]    <= bus.i_SPI_velocity;
            end
            if (w_off) r_gate[w_vidx] <= 1'b0;
            if (w_on && !w_cur_gate)
                r_count <= r_count + (VOICE_W+1)'(1);
            else if (w_off && w_cur_gate)
                r_count <= r_count - (VOICE_W+1)'(1);
            if (w_event && !w_in_range) r_drop <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_word  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_idx   <= r_ptr;
            r_frame <= (r_ptr == '0);
            r_word  <= '{gate: r_gate[r_ptr], retrig: r_retrig[r_ptr],
                         tuning: r_tuning[r_ptr], vel: r_vel[r_ptr]};
            r_ptr   <= (r_ptr == VOICE_W'(NUM_VOICES-1)) ? '0 : r_ptr + VOICE_W'(1);
        end
    end

    assign bus.o_voice_valid  = r_valid;
    assign bus.o_voice_index  = r_idx;
    assign bus.o_frame_start  = r_frame;
    assign bus.o_gate         = r_word.gate;
    assign bus.o_retrigger    = r_word.retrig;
    assign bus.o_tuning_code  = r_word.tuning;
    assign bus.o_velocity     = r_word.vel;
    assign bus.o_active_count = r_count;
    assign bus.o_drop         = r_drop;
endmodule
